// File: rtl/spi_slave_if.sv
// SPI slave front-end for the command-word RAM.
// Receives {cmd[1:0], payload} words MSB first from MOSI and strobes them out on rx_valid.
// Serialises the RAM read byte back onto MISO. One bit per clk cycle.
module spi_slave_if #(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int unsigned WordW = ADDR_SIZE + 2;
    localparam int unsigned CntW  = $clog2(WordW + 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StChkCmd   = 3'd1;
    localparam logic [2:0] StWrite    = 3'd2;
    localparam logic [2:0] StReadAdd  = 3'd3;
    localparam logic [2:0] StReadData = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [WordW-1:0]     rx_shift_q, rx_shift_d;
    logic                 rx_done_q, rx_done_d;
    logic [ADDR_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 rd_addr_seen_q, rd_addr_seen_d;
    logic                 miso_q, miso_d;
    logic [WordW-1:0]     rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;

    // Next-state logic: frame FSM, receive deserialiser and transmit serialiser.
    always_comb begin
        state_d        = state_q;
        rx_cnt_d       = rx_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_done_d      = rx_done_q;
        tx_shift_d     = tx_shift_q;
        tx_cnt_d       = tx_cnt_q;
        tx_busy_d      = tx_busy_q;
        tx_done_d      = tx_done_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        miso_d         = 1'b0;

        if (state_q != StIdle && SS_n) begin
            // Deselect ends or aborts the frame; partial words are dropped.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!SS_n) state_d = StChkCmd;
                end
                StChkCmd: begin
                    rx_shift_d = {{(WordW-1){1'b0}}, MOSI};
                    rx_cnt_d   = CntW'(ADDR_SIZE + 1);
                    rx_done_d  = 1'b0;
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b0;
                    if (!MOSI)               state_d = StWrite;
                    else if (!rd_addr_seen_q) state_d = StReadAdd;
                    else                     state_d = StReadData;
                end
                StWrite, StReadAdd, StReadData: begin
                    if (!rx_done_q) begin
                        rx_shift_d = {rx_shift_q[WordW-2:0], MOSI};
                        rx_cnt_d   = rx_cnt_q - CntW'(1);
                        if (rx_cnt_q == CntW'(1)) begin
                            rx_done_d  = 1'b1;
                            rx_data_d  = {rx_shift_q[WordW-2:0], MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == StReadAdd) rd_addr_seen_d = 1'b1;
                        end
                    end else if (state_q == StReadData && !tx_done_q) begin
                        if (tx_busy_q) begin
                            if (tx_cnt_q == CntW'(1)) begin
                                // Last bit has been on MISO for a cycle; the read is complete.
                                tx_busy_d      = 1'b0;
                                tx_done_d      = 1'b1;
                                rd_addr_seen_d = 1'b0;
                            end else begin
                                miso_d     = tx_shift_q[ADDR_SIZE-1];
                                tx_shift_d = tx_shift_q << 1;
                                tx_cnt_d   = tx_cnt_q - CntW'(1);
                            end
                        end else if (tx_valid) begin
                            // MSB goes out straight away; the rest shift from tx_shift.
                            miso_d     = tx_data[ADDR_SIZE-1];
                            tx_shift_d = tx_data << 1;
                            tx_cnt_d   = CntW'(ADDR_SIZE);
                            tx_busy_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            rx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            rx_done_q      <= 1'b0;
            tx_shift_q     <= '0;
            tx_cnt_q       <= '0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_done_q      <= rx_done_d;
            tx_shift_q     <= tx_shift_d;
            tx_cnt_q       <= tx_cnt_d;
            tx_busy_q      <= tx_busy_d;
            tx_done_q      <= tx_done_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            miso_q         <= miso_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame-level reference model, per-cycle comparison,
// directed frames with literal expectations, then randomized frames.
module tb_spi_slave_if;

    logic       clk;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    spi_slave_if #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model state carried between frames.
    bit         model_seen = 1'b0;
    logic [9:0] model_data = 10'h000;

    // Expected outputs after the coming rising edge.
    bit         check_en = 1'b0;
    logic       exp_valid = 1'b0;
    logic [9:0] exp_data = 10'h000;
    logic       exp_miso = 1'b0;
    int         cyc_idx = 0;
    logic       miso_cap [0:63];
    int         valid_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int miso_ones();
        int n = 0;
        for (int i = 0; i < 64; i++) if (miso_cap[i] === 1'b1) n++;
        return n;
    endfunction

    // Single compare process: every cycle, 2 time units after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (check_en) begin
                chk("rx_valid", 32'(rx_valid), 32'(exp_valid));
                chk("rx_data", 32'(rx_data), 32'(exp_data));
                chk("MISO", 32'(MISO), 32'(exp_miso));
                miso_cap[cyc_idx] = MISO;
                if (rx_valid === 1'b1) valid_cnt++;
            end
        end
    end

    // One SS_n-low period of len cycles followed by gap idle cycles. MOSI carries word[9:0]
    // in cycles 1..10. A tx_valid pulse with td is placed at cycle t; other tx_valid cycles
    // are random noise except the read-data wait window ahead of t. rst_at >= 0 asserts rst
    // at that cycle and ends the frame.
    task automatic run_frame(input logic [9:0] word, input int len, input int t, input int gap,
                             input logic [7:0] td, input int rst_at);
        int         n;
        bit         is_rd_data, is_rd_add, full, latched;
        logic [9:0] data_now;
        int         bi;
        n          = len + gap;
        is_rd_data = (len >= 2) && word[9] && model_seen;
        is_rd_add  = (len >= 2) && word[9] && !model_seen;
        full       = (len >= 11);
        latched    = is_rd_data && full && (t < len);
        data_now   = model_data;
        for (int i = 0; i < 64; i++) miso_cap[i] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_MISO", 32'(MISO), 32'd0);
                chk("rst_rx_valid", 32'(rx_valid), 32'd0);
                chk("rst_rx_data", 32'(rx_data), 32'd0);
                check_en  = 1'b0;
                exp_valid = 1'b0;
                exp_data  = 10'h000;
                exp_miso  = 1'b0;
                SS_n      = 1'b1;
                tx_valid  = 1'b0;
                @(negedge clk);
                rst        = 1'b0;
                model_seen = 1'b0;
                model_data = 10'h000;
                return;
            end
            SS_n    = (i < len) ? 1'b0 : 1'b1;
            MOSI    = (i >= 1 && i <= 10) ? word[4'(10 - i)] : 1'($urandom);
            tx_data = 8'($urandom);
            if (i == t) begin
                tx_valid = 1'b1;
                tx_data  = td;
            end else if (is_rd_data && full && i >= 11 && i < t) begin
                tx_valid = 1'b0;
            end else begin
                tx_valid = ($urandom_range(0, 3) == 0);
            end
            if (full && i == 10) data_now = word;
            exp_valid = full && (i == 10);
            exp_data  = data_now;
            bi        = 7 - (i - t);
            exp_miso  = (latched && i >= t && i <= t + 7 && i < len) ? td[3'(bi)] : 1'b0;
            cyc_idx   = i;
            check_en  = 1'b1;
        end
        model_data = data_now;
        if (is_rd_add && full) model_seen = 1'b1;
        if (latched && (t + 8 <= len - 1)) model_seen = 1'b0;
    endtask

    task automatic random_frame();
        logic [9:0] w;
        int         len, t, gap;
        bit         rd;
        w   = 10'($urandom);
        t   = 11 + int'($urandom_range(0, 3));
        gap = 1 + int'($urandom_range(0, 2));
        rd  = w[9] && model_seen;
        if ($urandom_range(0, 3) == 0)
            len = rd ? int'($urandom_range(1, t + 8)) : int'($urandom_range(1, 10));
        else
            len = rd ? t + 9 + int'($urandom_range(0, 2)) : 11 + int'($urandom_range(0, 4));
        run_frame(w, len, t, gap, 8'($urandom), -1);
    endtask

    int v0;

    initial begin
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_MISO", 32'(MISO), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);

        // Write address, then write data.
        v0 = valid_cnt;
        run_frame(10'h014, 12, 12, 2, 8'h00, -1);
        chk("wr_addr_data", 32'(rx_data), 32'h014);
        chk("wr_addr_pulses", 32'(valid_cnt - v0), 32'd1);
        chk("wr_addr_miso_quiet", 32'(miso_ones()), 32'd0);
        v0 = valid_cnt;
        run_frame(10'h1A5, 13, 11, 1, 8'h00, -1);
        chk("wr_data_data", 32'(rx_data), 32'h1A5);
        chk("wr_data_pulses", 32'(valid_cnt - v0), 32'd1);

        // Read address, then read data returning 8'hA5.
        run_frame(10'h214, 12, 12, 2, 8'h00, -1);
        chk("rd_addr_data", 32'(rx_data), 32'h214);
        run_frame(10'h3C7, 22, 12, 2, 8'hA5, -1);
        chk("rd_data_data", 32'(rx_data), 32'h3C7);
        chk("rd_data_miso_bits", 32'({miso_cap[12], miso_cap[13], miso_cap[14], miso_cap[15],
                                      miso_cap[16], miso_cap[17], miso_cap[18], miso_cap[19]}),
            32'hA5);
        chk("rd_data_miso_after", 32'(miso_cap[20]), 32'd0);
        // Read completed, so the next 1x frame is an address again: MISO stays quiet.
        run_frame(10'h255, 22, 12, 2, 8'hA5, -1);
        chk("rd_addr_again_quiet", 32'(miso_ones()), 32'd0);
        chk("rd_addr_again_data", 32'(rx_data), 32'h255);

        // Abort a write after 5 bits, then a full write.
        v0 = valid_cnt;
        run_frame(10'h0F0, 6, 12, 2, 8'h00, -1);
        chk("abort_pulses", 32'(valid_cnt - v0), 32'd0);
        chk("abort_data_held", 32'(rx_data), 32'h255);
        run_frame(10'h0AB, 12, 12, 2, 8'h00, -1);
        chk("after_abort_data", 32'(rx_data), 32'h0AB);

        // Reset during read-data shifting; the next 1x frame is a read address.
        run_frame(10'h3FF, 25, 12, 2, 8'hFF, 15);
        chk("pre_rst_miso_high", 32'(miso_cap[14]), 32'd1);
        run_frame(10'h3AA, 24, 12, 2, 8'hFF, -1);
        chk("post_rst_read_add_quiet", 32'(miso_ones()), 32'd0);
        chk("post_rst_data", 32'(rx_data), 32'h3AA);

        for (int k = 0; k < 80; k++) random_frame();

        @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
